pd_header_serializer: RTL and testbench



---
 rtl/pd_pkg.sv | 19 +
 rtl/pd_header_serializer_if.sv | 31 +++
 rtl/pd_header_serializer.sv | 130 +++++++++++++
 tb/tb_pd_header_serializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared definitions for the block-header datapath: header geometry, header type, serializer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pd_pkg;

  localparam int HEADER_BYTES      = 80;
  localparam int NONCE_OFFSET      = 76;
  localparam int DIFFICULTY_OFFSET = 72;

  typedef logic [HEADER_BYTES-1:0][7:0] header_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CSUM,
    DONE
  } serializer_state_t;

endpackage

// File: rtl/pd_header_serializer_if.sv
// Handshake/bus bundle between the header source, the serializer and the USB transmit path.
// Latency: n/a (wiring only).
// Backpressure: i_ready from the consumer side; the serializer holds o_data/o_byte_sel while it is low.
// Ports: i_start/i_header/i_nonce/i_ready flow into the serializer,
//        o_data/o_valid/o_byte_sel/o_busy/o_done flow out of it.
interface pd_header_serializer_if;
  import pd_pkg::*;

  logic        i_start;
  header_t     i_header;
  logic [31:0] i_nonce;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic [6:0]  o_byte_sel;
  logic        o_busy;
  logic        o_done;

  // Driver of requests / consumer of the byte stream.
  modport master (
    output i_start, i_header, i_nonce, i_ready,
    input  o_data, o_valid, o_byte_sel, o_busy, o_done
  );

  // The serializer itself.
  modport slave (
    input  i_start, i_header, i_nonce, i_ready,
    output o_data, o_valid, o_byte_sel, o_busy, o_done
  );

endinterface

// File: rtl/pd_header_serializer.sv
// Snapshots an 80-byte header with the winning nonce merged in and streams it one byte per handshake.
// Latency: o_valid one cycle after i_start; 1 byte/cycle while i_ready is held high.
// Backpressure: o_data/o_byte_sel held stable while i_ready is low.
// Ports: clk, rst (async, active-high), bus (pd_header_serializer_if.slave).
// Option: define PD_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte at o_byte_sel = NUM_BYTES.
// NUM_BYTES must match the width of pd_pkg::header_t.
module pd_header_serializer #(
  parameter int NUM_BYTES    = pd_pkg::HEADER_BYTES,
  parameter int NONCE_OFFSET = pd_pkg::NONCE_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst,
  pd_header_serializer_if.slave  bus
);
  import pd_pkg::*;

  localparam logic [6:0] LAST_SEL = 7'(NUM_BYTES - 1);
`ifdef PD_SERIALIZER_CHECKSUM_EN
  localparam logic [6:0] CSUM_SEL = 7'(NUM_BYTES);
`endif

  serializer_state_t state;
  header_t           snap;
  header_t           merged;
  logic [6:0]        next_sel;
`ifdef PD_SERIALIZER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Nonce is stored little-endian over the last four header bytes.
  always_comb begin
    merged = bus.i_header;
    for (int k = 0; k < 4; k++) begin
      merged[NONCE_OFFSET + k] = bus.i_nonce[8*k +: 8];
    end
  end

  // o_byte_sel doubles as the stream index.
  assign next_sel = bus.o_byte_sel + 7'd1;

  // Snapshot is only taken when a request is accepted, so later header/nonce
  // changes cannot disturb a stream in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (state == IDLE && bus.i_start) begin
      snap <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.o_data     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_byte_sel <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
`ifdef PD_SERIALIZER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state          <= SEND;
            bus.o_valid    <= 1'b1;
            bus.o_busy     <= 1'b1;
            bus.o_byte_sel <= '0;
            // Snapshot is not registered yet, so byte 0 comes straight from the merge.
            bus.o_data     <= merged[0];
`ifdef PD_SERIALIZER_CHECKSUM_EN
            csum           <= '0;
`endif
          end
        end

        SEND: begin
          if (bus.i_ready) begin
`ifdef PD_SERIALIZER_CHECKSUM_EN
            csum <= csum ^ bus.o_data;
`endif
            if (bus.o_byte_sel == LAST_SEL) begin
`ifdef PD_SERIALIZER_CHECKSUM_EN
              state          <= CSUM;
              bus.o_byte_sel <= CSUM_SEL;
              // Fold in the byte being accepted on this edge.
              bus.o_data     <= csum ^ bus.o_data;
`else
              state          <= DONE;
              bus.o_valid    <= 1'b0;
              bus.o_done     <= 1'b1;
`endif
            end else begin
              bus.o_byte_sel <= next_sel;
              bus.o_data     <= snap[next_sel];
            end
          end
        end

`ifdef PD_SERIALIZER_CHECKSUM_EN
        CSUM: begin
          if (bus.i_ready) begin
            state       <= DONE;
            bus.o_valid <= 1'b0;
            bus.o_done  <= 1'b1;
          end
        end
`endif

        DONE: begin
          // Any i_start seen here is deliberately dropped.
          state          <= IDLE;
          bus.o_done     <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_byte_sel <= '0;
          bus.o_data     <= '0;
        end

        default: begin
          state       <= IDLE;
          bus.o_valid <= 1'b0;
          bus.o_busy  <= 1'b0;
          bus.o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pd_header_serializer.sv
// Directed bench for pd_header_serializer: reset, basic stream, backpressure, start-in-DONE,
// back-to-back restart, snapshot isolation, async reset mid-stream.
// Latency/backpressure expectations are hand-computed from the header j=j, nonce 0xDEADBEEF pattern.
module tb_pd_header_serializer;
  import pd_pkg::*;

`ifdef PD_SERIALIZER_CHECKSUM_EN
  localparam int TOTAL = 81;
`else
  localparam int TOTAL = 80;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pd_header_serializer_if bus ();

  pd_header_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes 0..75 carry j; 76..79 carry 0xDEADBEEF little-endian.
  // Checksum: XOR of 0..75 is 0 (75 mod 4 == 3), EF^BE^AD^DE = 0x22.
  function automatic logic [7:0] exp_byte(input int j);
    case (j)
      76:      return 8'hEF;
      77:      return 8'hBE;
      78:      return 8'hAD;
      79:      return 8'hDE;
      80:      return 8'h22;
      default: return 8'(j);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_std_header();
    for (int j = 0; j < HEADER_BYTES; j++) bus.i_header[j] = 8'(j);
    bus.i_nonce = 32'hDEADBEEF;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  // Called #1 after the i_start edge. Returns early when idx reaches stop_at,
  // otherwise returns #1 after the edge that enters DONE.
  task automatic run_stream(input bit bp, input bit iso, input int stop_at);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit injected = 1'b0;
    while (idx < TOTAL && cyc < 1000) begin
      if (idx == stop_at) return;
      check("valid", {31'd0, bus.o_valid}, 32'd1);
      check("busy", {31'd0, bus.o_busy}, 32'd1);
      check("byte_sel", {25'd0, bus.o_byte_sel}, idx);
      check("data", {24'd0, bus.o_data}, {24'd0, exp_byte(idx)});
      rdy = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      bus.i_ready = rdy;
      if (iso && idx == 10 && !injected) begin
        for (int j = 0; j < HEADER_BYTES; j++) bus.i_header[j] = 8'hFF;
        bus.i_nonce = 32'hFFFFFFFF;
        bus.i_start = 1'b1;
        injected = 1'b1;
      end
      step();
      bus.i_start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    check("stream_len", idx, TOTAL);
    check("done_pulse", {31'd0, bus.o_done}, 32'd1);
    check("valid_in_done", {31'd0, bus.o_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_header = '0;
    bus.i_nonce = '0;
    step();
    step();
    check("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset_data", {24'd0, bus.o_data}, 32'd0);
    check("reset_sel", {25'd0, bus.o_byte_sel}, 32'd0);
    check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    check("reset_done", {31'd0, bus.o_done}, 32'd0);
    rst = 1'b0;
    step();

    // Basic stream, ready held high.
    load_std_header();
    check("idle_valid", {31'd0, bus.o_valid}, 32'd0);
    pulse_start();
    run_stream(1'b0, 1'b0, -1);

    // i_start during DONE is dropped; restart from the following IDLE cycle.
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    check("start_in_done_valid", {31'd0, bus.o_valid}, 32'd0);
    check("start_in_done_busy", {31'd0, bus.o_busy}, 32'd0);
    check("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
    pulse_start();
    run_stream(1'b1, 1'b0, -1);   // back-to-back with 1,0,0,1 backpressure
    step();
    check("idle_after_bp", {31'd0, bus.o_busy}, 32'd0);

    // Snapshot isolation: header overwritten and i_start pulsed at byte 10.
    pulse_start();
    run_stream(1'b0, 1'b1, -1);
    step();
    check("no_restart_valid", {31'd0, bus.o_valid}, 32'd0);
    check("no_restart_busy", {31'd0, bus.o_busy}, 32'd0);
    load_std_header();

    // Async reset at byte 40.
    pulse_start();
    run_stream(1'b0, 1'b0, 40);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("midrst_data", {24'd0, bus.o_data}, 32'd0);
    check("midrst_sel", {25'd0, bus.o_byte_sel}, 32'd0);
    check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("midrst_done", {31'd0, bus.o_done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_no_done", {31'd0, bus.o_done}, 32'd0);
    end
    #2 rst = 1'b0;
    step();
    check("post_rst_idle", {31'd0, bus.o_valid}, 32'd0);
    pulse_start();
    run_stream(1'b0, 1'b0, -1);
    step();
    check("final_idle", {31'd0, bus.o_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
